// File: rtl/result_lane_aligner_pkg.sv
// Shared types for the four-lane result path: lane indices, result width and
// the packed layout of one assembled 4-lane result set.
package result_lane_aligner_pkg;

  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {
    LANE_A = 2'd0,
    LANE_B = 2'd1,
    LANE_C = 2'd2,
    LANE_D = 2'd3
  } lane_e;

  // Pipeline results carry one extra bit of growth over the operands.
  function automatic int res_w(input int datawidth);
    return datawidth + 1;
  endfunction

  localparam int DEFAULT_DATAWIDTH = 16;
  localparam int DEFAULT_RES_W     = res_w(DEFAULT_DATAWIDTH);

  typedef struct packed {
    logic [DEFAULT_RES_W-1:0] a;
    logic [DEFAULT_RES_W-1:0] b;
    logic [DEFAULT_RES_W-1:0] c;
    logic [DEFAULT_RES_W-1:0] d;
  } result_set_t;

endpackage

// File: rtl/result_lane_aligner_if.sv
// Bundle of lane strobes/results from the pipeline and the ready/valid set
// output toward the consumer. The aligner sits on the slave modport.
interface result_lane_aligner_if
  import result_lane_aligner_pkg::*;
#(
  parameter int DATAWIDTH = 16
);
  localparam int RW = res_w(DATAWIDTH);

  logic          i_valid_a, i_valid_b, i_valid_c, i_valid_d;
  logic [RW-1:0] i_data_a, i_data_b, i_data_c, i_data_d;
  logic          o_valid;
  logic          i_ready;
  logic [RW-1:0] o_data_a, o_data_b, o_data_c, o_data_d;
  logic [3:0]    o_overflow;
  logic [15:0]   o_set_count;

  modport master (
    output i_valid_a, i_valid_b, i_valid_c, i_valid_d,
    output i_data_a, i_data_b, i_data_c, i_data_d,
    output i_ready,
    input  o_valid, o_data_a, o_data_b, o_data_c, o_data_d,
    input  o_overflow, o_set_count
  );

  modport slave (
    input  i_valid_a, i_valid_b, i_valid_c, i_valid_d,
    input  i_data_a, i_data_b, i_data_c, i_data_d,
    input  i_ready,
    output o_valid, o_data_a, o_data_b, o_data_c, o_data_d,
    output o_overflow, o_set_count
  );

endinterface

// File: rtl/result_lane_aligner_lane_fifo.sv
// Single-clock show-ahead FIFO buffering one lane's results. A push into a
// full FIFO is only taken when a pop frees the slot in the same cycle.
module lane_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q];

  // NOTE: every variable gets a default first, so always_comb never infers a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/result_lane_aligner.sv
// Collects independently-timed lane results into per-lane FIFOs and emits
// ordered 4-lane sets through a single ready/valid output register.
module result_lane_aligner
  import result_lane_aligner_pkg::*;
#(
  parameter int DATAWIDTH  = 16,
  parameter int FIFO_DEPTH = 8
) (
  input logic                  clk,
  input logic                  rst,
  result_lane_aligner_if.slave bus
);
  localparam int RW = res_w(DATAWIDTH);

  logic [NUM_LANES-1:0] in_valid, fifo_empty, fifo_full;
  logic [RW-1:0]        in_data [NUM_LANES];
  logic [RW-1:0]        head    [NUM_LANES];
  logic                 load, xfer;

  logic                 valid_q, valid_d;
  logic [RW-1:0]        data_q [NUM_LANES];
  logic [RW-1:0]        data_d [NUM_LANES];
  logic [3:0]           overflow_q, overflow_d;
  logic [15:0]          set_count_q, set_count_d;

  assign in_valid         = {bus.i_valid_d, bus.i_valid_c, bus.i_valid_b, bus.i_valid_a};
  assign in_data[LANE_A]  = bus.i_data_a;
  assign in_data[LANE_B]  = bus.i_data_b;
  assign in_data[LANE_C]  = bus.i_data_c;
  assign in_data[LANE_D]  = bus.i_data_d;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_fifo #(
      .WIDTH (RW),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (in_valid[i]),
      .pop   (load),
      .din   (in_data[i]),
      .dout  (head[i]),
      .empty (fifo_empty[i]),
      .full  (fifo_full[i])
    );
  end

  // All lanes pop together, which is what keeps the k-th samples in one set.
  assign load = ~|fifo_empty && (!valid_q || bus.i_ready);
  assign xfer = valid_q && bus.i_ready;

  always_comb begin
    valid_d     = valid_q;
    data_d      = data_q;
    set_count_d = set_count_q + 16'(xfer);
    // A strobe into a full lane survives only if this cycle's load frees a slot.
    overflow_d  = overflow_q | (in_valid & fifo_full & {NUM_LANES{~load}});
    if (load) begin
      valid_d = 1'b1;
      data_d  = head;
    end else if (xfer) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      data_q      <= '{default: '0};
      overflow_q  <= '0;
      set_count_q <= '0;
    end else begin
      valid_q     <= valid_d;
      data_q      <= data_d;
      overflow_q  <= overflow_d;
      set_count_q <= set_count_d;
    end
  end

  assign bus.o_valid     = valid_q;
  assign bus.o_data_a    = data_q[LANE_A];
  assign bus.o_data_b    = data_q[LANE_B];
  assign bus.o_data_c    = data_q[LANE_C];
  assign bus.o_data_d    = data_q[LANE_D];
  assign bus.o_overflow  = overflow_q;
  assign bus.o_set_count = set_count_q;

endmodule

// File: doc/result_lane_aligner.md
Name: result_lane_aligner

Overview:
- Downstream collector for the four-lane arithmetic pipeline top (lanes A–D, DATAWIDTH+1-bit results).
- Each lane's result arrives with its own valid strobe, and lanes may complete on different cycles.
- The block buffers each lane independently, then re-assembles ordered 4-lane result sets.
- It presents each set on a ready/valid output interface toward the consumer (checker, host interface, writeback).

Parameters:
- DATAWIDTH, 16, input operand width of the pipeline; lane result width is DATAWIDTH+1.
- FIFO_DEPTH, 8, entries per lane buffer; power of two, minimum 2.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- i_valid_a  in  1  lane A result strobe (pipeline o_valid_final_A). Lanes B–D identical: i_valid_b, i_valid_c, i_valid_d.
- i_data_a  in  DATAWIDTH+1  lane A result. Lanes B–D identical: i_data_b, i_data_c, i_data_d.
- o_valid  out  1  assembled set available.
- i_ready  in  1  consumer accepts the set.
- o_data_a  out  DATAWIDTH+1  assembled lane A value. Lanes B–D identical: o_data_b, o_data_c, o_data_d.
- o_overflow  out  4  sticky per-lane drop flag; bit 0 = A, bit 3 = D.
- o_set_count  out  16  number of completed output handshakes.

Behaviour:
- Reset: rst high at an edge clears all of the following:
  - FIFO pointers and occupancy.
  - Output register and o_valid.
  - All o_data_* to 0.
  - o_overflow to 0.
  - o_set_count to 0.
  - Inputs sampled during a reset cycle are discarded.
  - Reset mid-operation drops all buffered data; no stale set may appear after reset.
- Upstream has no backpressure. Every strobe must be accepted or counted as a drop.
- Lane push: i_valid_x high at an edge writes i_data_x into lane FIFO x.
- Full lane: if FIFO x is full and no pop occurs that cycle, the sample is dropped and o_overflow[x] is set.
  - The flag stays set until rst.
  - Full + push + pop in the same cycle is accepted, with no drop.
- Output register: a single stage holding one set, with o_valid as its occupancy flag.
- Load condition: (all four FIFOs non-empty) AND (o_valid==0 OR i_ready==1).
  - On load, the block pops one entry from every FIFO simultaneously and registers the head values.
  - o_valid stays 1 on back-to-back loads.
- Handshake: a transfer occurs on any edge with o_valid && i_ready.
  - If no new load follows, o_valid drops to 0 next cycle.
  - While o_valid && !i_ready, o_data_* stay stable.
- Latency: a set whose last lane strobe occurs in cycle t, with otherwise empty FIFOs and register, shows o_valid=1 in cycle t+2.
- Throughput: 1 set per cycle when i_ready is held high.
- Ordering: the k-th sample of every lane forms set k. Lanes are never reordered or mixed across sets.
- o_set_count: increments on each transfer and wraps 0xFFFF→0x0000.
- Simultaneous strobes on all lanes with full FIFOs and a concurrent load: all four accepted.

Decomposition:
- Shared package (pipeline-wide):
  - NUM_LANES = 4.
  - Lane index enum (LANE_A..LANE_D).
  - Result-width function res_w(DATAWIDTH) = DATAWIDTH+1.
  - Packed struct type for a 4-lane result set.
- Sub-module lane_fifo: synchronous single-clock FIFO, instantiated once per lane.
  - Inputs: push, pop, din.
  - Outputs: dout (show-ahead head), empty, full.
  - Uses the same clk/rst scheme.

Test Plan:
- Reset: rst high 5 cycles with random strobes → after release, o_valid=0, o_data_*=0, o_overflow=4'b0000, o_set_count=0.
- Aligned: all lanes strobe in cycle t with 0x00100/0x00200/0x00300/0x00400, i_ready=1 → o_valid high in cycle t+2 only, with those values; o_set_count=1.
- Skewed: A strobes at t, B at t+1, C at t+3, D at t+5 (values 0x1100/0x1500/0x2500/0x8800) → o_valid first at t+7 with that set; nothing earlier.
- Backpressure: i_ready=0, three aligned sets S1..S3 → o_valid holds S1 stable. Then i_ready=1 → S1, S2, S3 on consecutive cycles; o_set_count=3.
- Overflow: i_ready=0, lane A alone strobes 10 values 1..10 → o_overflow=4'b0001. Then lanes B/C/D each strobe 8 values with i_ready=1 → 8 sets out, A values 1..8; no further sets.
- Reset mid-stream: 3 sets buffered, o_valid=1, i_ready=0, rst one cycle → next cycle o_valid=0. With no new strobes for 10 cycles, o_valid stays 0.
